result_link_arbiter: RTL

Shares the single byte-wide result link between `NUM_SOURCES` decoder controllers. Each controller emits fixed-length result packets: 3 header bytes (iteration count, cycle count high, cycle count low) followed by the serialized correction bytes. The arbiter grants the link round-robin, one whole packet at a time, so packets are never interleaved. It sits between the per-decoder controllers' output ports and the host-facing output FIFO/UART.

---
 rtl/result_link_arbiter_pkg.sv | 17 +
 rtl/result_link_arbiter_rr_pick.sv | 32 +++
 rtl/result_link_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/result_link_arbiter_pkg.sv
// Shared constants for the result link arbiter.
// The optional RESULT_LINK_TAG_EN build adds a per-packet source tag byte.
package result_link_arbiter_pkg;

  localparam int unsigned GRANT_W = 4;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned COUNT_W = 16;

  localparam logic [3:0] RESULT_TAG_PREFIX = 4'hF;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_TAG     = 2'd1,
    ARB_FORWARD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/result_link_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
// Used by result_link_arbiter (RESULT_LINK_TAG_EN has no effect here).
module rr_pick
  import result_link_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = 4
) (
  input  logic [NUM_SOURCES-1:0] req,
  input  logic [GRANT_W-1:0]     last_grant,
  output logic [GRANT_W-1:0]     grant_c,
  output logic                   any_req_c
);

  logic [GRANT_W-1:0] cand;

  // Scan offsets 1..NUM_SOURCES so last_grant itself is considered last.
  always_comb begin
    grant_c   = '0;
    any_req_c = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_SOURCES; k++) begin
      cand = GRANT_W'((32'(last_grant) + k) % NUM_SOURCES);
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
        if (!any_req_c && (cand == GRANT_W'(i)) && req[i]) begin
          grant_c   = cand;
          any_req_c = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/result_link_arbiter.sv
// Round-robin, packet-granular arbiter sharing one byte-wide result link.
// Define RESULT_LINK_TAG_EN to prefix each packet with a {4'hF, source} tag byte.
module result_link_arbiter
  import result_link_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SOURCES  = 4,
  parameter int unsigned PACKET_BYTES = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BYTE_W*NUM_SOURCES-1:0] in_data,
  input  logic [NUM_SOURCES-1:0]        in_valid,
  output logic [NUM_SOURCES-1:0]        in_ready,
  output logic [BYTE_W-1:0]             output_data,
  output logic                          output_valid,
  input  logic                          output_ready,
  output logic [GRANT_W-1:0]            grant_id,
  output logic                          busy,
  output logic [COUNT_W-1:0]            packet_count
);

  localparam int unsigned        CNT_W     = $clog2(PACKET_BYTES + 1);
  localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(PACKET_BYTES - 1);
  localparam logic [GRANT_W-1:0] LAST_SRC  = GRANT_W'(NUM_SOURCES - 1);

  arb_state_e           state, state_d;
  logic [GRANT_W-1:0]   last_grant, last_grant_d, grant_d;
  logic [GRANT_W-1:0]   pick_c;
  logic                 any_req_c;
  logic [CNT_W-1:0]     byte_cnt, byte_cnt_d;
  logic [COUNT_W-1:0]   packet_count_d;
  logic [BYTE_W-1:0]    sel_data;
  logic                 sel_valid;

  rr_pick #(
    .NUM_SOURCES(NUM_SOURCES)
  ) u_pick (
    .req       (in_valid),
    .last_grant(last_grant),
    .grant_c   (pick_c),
    .any_req_c (any_req_c)
  );

  // Mux of the granted source's byte and valid.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if (grant_id == GRANT_W'(i)) begin
        sel_data  = in_data[BYTE_W*i +: BYTE_W];
        sel_valid = in_valid[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ARB_IDLE;
      grant_id     <= '0;
      last_grant   <= LAST_SRC;
      byte_cnt     <= '0;
      packet_count <= '0;
    end else begin
      state        <= state_d;
      grant_id     <= grant_d;
      last_grant   <= last_grant_d;
      byte_cnt     <= byte_cnt_d;
      packet_count <= packet_count_d;
    end
  end

  // Next state plus the combinational link pass-through.
  always_comb begin
    state_d        = state;
    grant_d        = grant_id;
    last_grant_d   = last_grant;
    byte_cnt_d     = byte_cnt;
    packet_count_d = packet_count;
    output_data    = '0;
    output_valid   = 1'b0;
    in_ready       = '0;
    case (state)
      ARB_IDLE: begin
        if (any_req_c) begin
          grant_d      = pick_c;
          last_grant_d = pick_c;
          byte_cnt_d   = '0;
`ifdef RESULT_LINK_TAG_EN
          state_d      = ARB_TAG;
`else
          state_d      = ARB_FORWARD;
`endif
        end
      end
`ifdef RESULT_LINK_TAG_EN
      ARB_TAG: begin
        output_valid = 1'b1;
        output_data  = {RESULT_TAG_PREFIX, grant_id};
        if (output_ready) begin
          state_d = ARB_FORWARD;
        end
      end
`endif
      ARB_FORWARD: begin
        output_data  = sel_data;
        output_valid = sel_valid;
        for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
          in_ready[i] = (grant_id == GRANT_W'(i)) && output_ready;
        end
        if (sel_valid && output_ready) begin
          byte_cnt_d = byte_cnt + CNT_W'(1);
          if (byte_cnt == LAST_BYTE) begin
            state_d        = ARB_IDLE;
            grant_d        = '0;
            packet_count_d = packet_count + COUNT_W'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign busy = (state != ARB_IDLE);

endmodule
